inst_encode_loader: RTL and testbench
=====================================

Name: inst_encode_loader

Overview:
- Encodes RV32I instructions from decoded fields (opcode[6:2], funct3, funct7 bit 5, rd, rs1, rs2, imm) into 32-bit words.
- Each encoded word is written sequentially into instruction memory starting at BASE_ADDR.
- It is the encoder counterpart of the single-cycle core's control decoder and is used to build program images and self-check test programs in simulation/FPGA.
- A one-entry registered output stage decouples the field producer from the memory write port.

Parameters:
- ADDR_W, 8: instruction memory word-address width (capacity 2^ADDR_W words).
- BASE_ADDR, 0: first word address written after start.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse: load address = BASE_ADDR, clear count/err, enter RUN.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  bundle accepted when in_valid && in_ready.
- in_last  in  1  marks the final instruction of the program.
- in_op  in  5  instruction opcode bits [6:2].
- in_funct3  in  3  funct3.
- in_f7b5  in  1  instruction bit 30 (SUB/SRA/SRAI).
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  32  immediate as a byte offset or value; U-type uses imm[31:12].
- mem_we  out  1  write request (output stage valid).
- mem_ready  in  1  memory accepts write when mem_we && mem_ready.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  encoded instruction.
- count  out  ADDR_W+1  number of completed writes.
- done  out  1  one-cycle pulse after the last write completes.
- err  out  1  sticky illegal-opcode or overflow flag.

Behaviour:
- Reset values: state=IDLE; in_ready, mem_we, done, err = 0; mem_addr=BASE_ADDR; mem_wdata=0; count=0.
- States and transitions:
  - IDLE: in_ready=0. start -> RUN.
  - RUN: in_ready = !mem_we || mem_ready. Accept with in_last=1 -> FLUSH.
  - FLUSH: in_ready=0. Wait for the final write to complete (or no pending write) -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- start in any state aborts: pending output dropped (mem_we=0), address/count/err reinitialised, state -> RUN.
- Latency: a bundle accepted in cycle N is presented with mem_we=1 in cycle N+1. Back-to-back throughput is 1/cycle while mem_ready=1.
- mem_we is held with stable addr/wdata until mem_ready. On completion, mem_addr and count increment by 1.
- Encoding (opcode field = {in_op, 2'b11}):
  - R (01100): {1'b0, f7b5, 5'b0, rs2, rs1, f3, rd, op}.
  - I-logic (00100): imm[11:0]. For f3=001/101, bits[31:25] = {0, f7b5, 00000} and bits[24:20] = imm[4:0].
  - Load (00000), JALR (11001): {imm[11:0], rs1, f3, rd, op}.
  - S (01000): {imm[11:5], rs2, rs1, f3, imm[4:0], op}.
  - B (11000): {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}.
  - LUI (01101), AUIPC (00101): {imm[31:12], rd, op}.
  - JAL (11011): {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
  - Unused fields and imm[0] for B/J are ignored; no range checking.
- Illegal in_op: bundle accepted, nothing written, err=1. in_last is still honoured.
- Overflow: once count = 2^ADDR_W, further accepts are dropped, err=1, address does not wrap.
- rst mid-operation: immediate return to reset values; no partial write held.

Test Plan:
- Reset, start, then ADD x3,x1,x2 (op=01100, f3=0, f7b5=0) -> cycle+1: mem_we=1, addr 0, wdata 0x002081B3; count=1 after mem_ready.
- Stream SUB x5,x6,x7; ADDI x1,x0,-1; SW x2,8(x1); BEQ x1,x2,+8; JAL x1,+16; LUI x2 with imm=0x12345000, last=1, mem_ready=1 -> wdata 0x407302B3, 0xFFF00093, 0x0020A423, 0x00208463, 0x010000EF, 0x12345137 at addr 0..5; done pulses once; count=6.
- mem_ready held 0 for 3 cycles during the stream -> mem_we/addr/wdata stable, in_ready=0, no bundle lost or duplicated.
- in_op=11111 between two ADDIs -> err=1, only 2 words written at addr 0,1.
- ADDR_W=2: send 5 bundles -> 4 written (addr 0..3), 5th dropped, err=1, count=4.
- Assert rst while mem_we=1 and mem_ready=0 -> all outputs at reset values the same cycle; start then re-runs from addr BASE_ADDR.

Source files
------------

// File: rtl/inst_encode_loader.sv
// RV32I instruction encoder that streams encoded words into instruction memory.
// A one-entry registered output stage sits between the field producer and the write port.
module inst_encode_loader #(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [4:0]        in_op,
  input  logic [2:0]        in_funct3,
  input  logic              in_f7b5,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   CAP  = {1'b1, {ADDR_W{1'b0}}};

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                err_q, err_d;

  logic                accept, fire, full;
  logic [ADDR_W:0]     count_inc;
  logic [6:0]          op7;
  logic [31:0]         enc_word;
  logic                enc_legal;

  assign accept    = in_valid && in_ready;
  assign fire      = we_q && mem_ready;
  assign count_inc = count_q + (ADDR_W+1)'(1);
  // A bundle overflows when every address slot is already taken by a
  // completed write or by the write completing this very cycle.
  assign full      = (count_q + (ADDR_W+1)'(fire)) == CAP;

  // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    op7       = {in_op, 2'b11};
    enc_word  = '0;
    enc_legal = 1'b1;
    case (in_op)
      OP_R:      enc_word = {1'b0, in_f7b5, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, op7};
      OP_IMM: begin
        if (in_funct3 == 3'b001 || in_funct3 == 3'b101)
          enc_word = {1'b0, in_f7b5, 5'b0, in_imm[4:0], in_rs1, in_funct3, in_rd, op7};
        else
          enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, op7};
      end
      OP_LOAD,
      OP_JALR:   enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, op7};
      OP_STORE:  enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], op7};
      OP_BRANCH: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                             in_imm[4:1], in_imm[11], op7};
      OP_LUI,
      OP_AUIPC:  enc_word = {in_imm[31:12], in_rd, op7};
      OP_JAL:    enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, op7};
      default:   enc_legal = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; next-state logic lives in always_comb.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= BASE;
      wdata_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = RUN;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        RUN:     if (accept && in_last) state_d = FLUSH;
        FLUSH:   if (!we_q || mem_ready) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready = (state_q == RUN) && !start && (!we_q || mem_ready);
    done     = (state_q == DONE);
  end

  always_comb begin
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    err_d   = err_q;
    if (start) begin
      we_d    = 1'b0;
      addr_d  = BASE;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      if (fire) begin
        we_d    = 1'b0;
        count_d = count_inc;
        // The address parks on the last slot instead of wrapping once memory is full.
        if (count_inc != CAP) addr_d = addr_q + ADDR_W'(1);
      end
      if (accept) begin
        if (!enc_legal || full) begin
          err_d = 1'b1;
        end else begin
          we_d    = 1'b1;
          wdata_d = enc_word;
        end
      end
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign count     = count_q;
  assign err       = err_q;

endmodule

// File: tb/tb_inst_encode_loader.sv
// Scoreboard bench for inst_encode_loader: a driver feeds bundles and predicts writes,
// a monitor pops predictions whenever a write completes. Two instances cover ADDR_W=8 and 2.
module tb_inst_encode_loader;

  typedef struct {
    logic [4:0]  op;
    logic [2:0]  f3;
    logic        f7b5;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    bit          has_known;
    logic [31:0] known;
  } bundle_t;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_last, mem_ready;
  logic [4:0]  in_op, in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic        in_f7b5;
  logic [31:0] in_imm;
  bit          sel;

  logic        a_in_ready, a_we, a_done, a_err;
  logic [7:0]  a_addr;
  logic [31:0] a_wdata;
  logic [8:0]  a_count;
  logic        b_in_ready, b_we, b_done, b_err;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata;
  logic [2:0]  b_count;

  logic start_a, start_b, valid_a, valid_b;
  logic        in_ready_s, we_s, done_s, err_s;
  logic [7:0]  addr_s;
  logic [31:0] wdata_s;
  logic [8:0]  count_s;

  assign start_a    = start & ~sel;
  assign start_b    = start & sel;
  assign valid_a    = in_valid & ~sel;
  assign valid_b    = in_valid & sel;
  assign in_ready_s = sel ? b_in_ready : a_in_ready;
  assign we_s       = sel ? b_we : a_we;
  assign done_s     = sel ? b_done : a_done;
  assign err_s      = sel ? b_err : a_err;
  assign addr_s     = sel ? {6'b0, b_addr} : a_addr;
  assign wdata_s    = sel ? b_wdata : a_wdata;
  assign count_s    = sel ? {6'b0, b_count} : a_count;

  inst_encode_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .in_valid(valid_a), .in_ready(a_in_ready),
    .in_last(in_last), .in_op(in_op), .in_funct3(in_funct3), .in_f7b5(in_f7b5),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .mem_we(a_we), .mem_ready(mem_ready), .mem_addr(a_addr), .mem_wdata(a_wdata),
    .count(a_count), .done(a_done), .err(a_err)
  );

  inst_encode_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in_valid(valid_b), .in_ready(b_in_ready),
    .in_last(in_last), .in_op(in_op), .in_funct3(in_funct3), .in_f7b5(in_f7b5),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .mem_we(b_we), .mem_ready(mem_ready), .mem_addr(b_addr), .mem_wdata(b_wdata),
    .count(b_count), .done(b_done), .err(b_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  wr_t     exp_q[$];
  int      lat_q[$];
  int      exp_issued;
  int      cap;
  bit      exp_err;
  int      done_cnt;
  int      cyc = 0;
  int      stall_cnt = 0;
  bit      rnd_ready = 0;
  bundle_t prog[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit is_legal(input logic [4:0] op);
    case (op)
      5'b01100, 5'b00100, 5'b00000, 5'b11001, 5'b01000,
      5'b11000, 5'b01101, 5'b00101, 5'b11011: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Instruction word built from field positions by shifting and masking.
  function automatic logic [31:0] encode(input bundle_t b);
    logic [31:0] op7, rd, rs1, rs2, f3, f7, imm, w;
    op7 = 32'(b.op) * 4 + 3;
    rd  = 32'(b.rd) << 7;
    f3  = 32'(b.f3) << 12;
    rs1 = 32'(b.rs1) << 15;
    rs2 = 32'(b.rs2) << 20;
    f7  = 32'(b.f7b5) << 30;
    imm = b.imm;
    case (b.op)
      5'b01100: w = f7 | rs2 | rs1 | f3 | rd | op7;
      5'b00100: begin
        if (b.f3 == 3'd1 || b.f3 == 3'd5) w = f7 | ((imm & 32'h1F) << 20) | rs1 | f3 | rd | op7;
        else                              w = ((imm & 32'hFFF) << 20) | rs1 | f3 | rd | op7;
      end
      5'b00000, 5'b11001: w = ((imm & 32'hFFF) << 20) | rs1 | f3 | rd | op7;
      5'b01000: w = (((imm >> 5) & 32'h7F) << 25) | rs2 | rs1 | f3 | ((imm & 32'h1F) << 7) | op7;
      5'b11000: w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | rs2 | rs1 | f3
                    | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | op7;
      5'b01101, 5'b00101: w = (imm & 32'hFFFFF000) | rd | op7;
      5'b11011: w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                    | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | rd | op7;
      default:  w = 32'h0;
    endcase
    return w;
  endfunction

  function automatic void model_accept(input bundle_t b);
    wr_t w;
    if (!is_legal(b.op) || exp_issued >= cap) begin
      exp_err = 1'b1;
    end else begin
      w.addr = 8'(exp_issued);
      w.data = b.has_known ? b.known : encode(b);
      exp_q.push_back(w);
      lat_q.push_back(cyc);
      exp_issued++;
    end
  endfunction

  function automatic bundle_t mk(input logic [4:0] op, input logic [2:0] f3, input logic f7b5,
                                 input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [31:0] imm, input logic [31:0] known);
    bundle_t b;
    b.op = op; b.f3 = f3; b.f7b5 = f7b5; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2;
    b.imm = imm; b.has_known = 1'b1; b.known = known;
    return b;
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t    b;
    logic [4:0] legal_ops [9] = '{5'b01100, 5'b00100, 5'b00000, 5'b11001, 5'b01000,
                                  5'b11000, 5'b01101, 5'b00101, 5'b11011};
    if ($urandom_range(9) == 0) begin
      b.op = 5'b11111;
      for (int t = 0; t < 8; t++) begin
        b.op = 5'($urandom);
        if (!is_legal(b.op)) break;
      end
      if (is_legal(b.op)) b.op = 5'b11111;
    end else begin
      b.op = legal_ops[$urandom_range(8)];
    end
    b.f3 = 3'($urandom); b.f7b5 = 1'($urandom);
    b.rd = 5'($urandom); b.rs1 = 5'($urandom); b.rs2 = 5'($urandom);
    b.imm = $urandom; b.has_known = 1'b0; b.known = '0;
    return b;
  endfunction

  always @(negedge clk) begin
    if (stall_cnt > 0) begin
      mem_ready = 1'b0;
      stall_cnt--;
    end else if (rnd_ready) begin
      mem_ready = ($urandom_range(3) != 0);
    end else begin
      mem_ready = 1'b1;
    end
  end

  // Monitor: checks handshake rules and pops the scoreboard on every completed write.
  bit          prev_hold = 0;
  logic [7:0]  prev_addr;
  logic [31:0] prev_wdata;
  always @(negedge clk) begin
    wr_t w;
    #2;
    if (rst) begin
      prev_hold = 0;
    end else begin
      while (lat_q.size() > 0 && lat_q[0] == cyc - 1) begin
        check("latency_we", 32'(we_s), 32'd1);
        void'(lat_q.pop_front());
      end
      if (prev_hold) begin
        check("hold_we", 32'(we_s), 32'd1);
        check("hold_addr", 32'(addr_s), 32'(prev_addr));
        check("hold_wdata", wdata_s, prev_wdata);
      end
      if (we_s && !mem_ready) check("in_ready_while_stalled", 32'(in_ready_s), 32'd0);
      if (we_s && mem_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(addr_s), 32'hFFFF_FFFF);
        end else begin
          w = exp_q.pop_front();
          check("wr_addr", 32'(addr_s), 32'(w.addr));
          check("wr_data", wdata_s, w.data);
        end
      end
      if (done_s) done_cnt++;
      prev_hold  = we_s && !mem_ready;
      prev_addr  = addr_s;
      prev_wdata = wdata_s;
    end
  end

  // Caller sits just after a falling edge; returns just after the next one following acceptance.
  task automatic send(input bundle_t b, input bit last);
    int waited;
    waited = 0;
    in_valid = 1'b1; in_last = last;
    in_op = b.op; in_funct3 = b.f3; in_f7b5 = b.f7b5;
    in_rd = b.rd; in_rs1 = b.rs1; in_rs2 = b.rs2; in_imm = b.imm;
    #1;
    while (!in_ready_s && waited < 100) begin
      @(negedge clk); #1;
      waited++;
    end
    if (!in_ready_s) begin
      check("accept_timeout", 32'(waited), 32'd0);
    end else begin
      model_accept(b);
    end
    @(negedge clk);
  endtask

  task automatic run_prog(input bit s, input int c, input bit bubbles, input int stall_at);
    int waited;
    int exp_addr;
    sel = s; cap = c; exp_issued = 0; exp_err = 0; done_cnt = 0;
    exp_q.delete(); lat_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    foreach (prog[i]) begin
      if (bubbles && $urandom_range(3) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      if (i == stall_at) stall_cnt = 3;
      send(prog[i], i == prog.size() - 1);
    end
    in_valid = 1'b0; in_last = 1'b0;
    waited = 0;
    #3;
    while (done_cnt == 0 && waited < 200) begin
      @(negedge clk); #3;
      waited++;
    end
    repeat (3) @(negedge clk);
    exp_addr = (exp_issued == cap) ? cap - 1 : exp_issued;
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("writes_left", 32'(exp_q.size()), 32'd0);
    check("final_count", 32'(count_s), 32'(exp_issued));
    check("final_err", 32'(err_s), 32'(exp_err));
    check("final_addr", 32'(addr_s), 32'(exp_addr));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; sel = 1'b0;
    in_op = '0; in_funct3 = '0; in_f7b5 = 1'b0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_we", 32'(a_we), 32'd0);
    check("rst_in_ready", 32'(a_in_ready), 32'd0);
    check("rst_addr", 32'(a_addr), 32'd0);
    check("rst_wdata", a_wdata, 32'd0);
    check("rst_count", 32'(a_count), 32'd0);
    check("rst_done", 32'(a_done), 32'd0);
    check("rst_err", 32'(a_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("idle_in_ready", 32'(a_in_ready), 32'd0);
    @(negedge clk);

    // Single ADD x3,x1,x2
    prog.delete();
    prog.push_back(mk(5'b01100, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3));
    run_prog(1'b0, 256, 1'b0, -1);

    // Directed stream, then the same stream with a 3-cycle memory stall
    prog.delete();
    prog.push_back(mk(5'b01100, 3'd0, 1'b1, 5'd5, 5'd6, 5'd7, 32'd0, 32'h407302B3));
    prog.push_back(mk(5'b00100, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFF00093));
    prog.push_back(mk(5'b01000, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020A423));
    prog.push_back(mk(5'b11000, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h00208463));
    prog.push_back(mk(5'b11011, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd16, 32'h010000EF));
    prog.push_back(mk(5'b01101, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'h12345000, 32'h12345137));
    run_prog(1'b0, 256, 1'b0, -1);
    run_prog(1'b0, 256, 1'b0, 2);

    // Illegal opcode between two ADDIs
    prog.delete();
    prog.push_back(mk(5'b00100, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093));
    prog.push_back(mk(5'b11111, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0));
    prog.push_back(mk(5'b00100, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd7, 32'h00700113));
    run_prog(1'b0, 256, 1'b0, -1);

    // Overflow on the 4-word instance
    prog.delete();
    for (int i = 0; i < 5; i++) begin
      bundle_t b;
      b = rand_bundle();
      b.op = 5'b00100;
      prog.push_back(b);
    end
    run_prog(1'b1, 4, 1'b0, -1);

    // Randomised programs with random back-pressure and bubbles
    rnd_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      prog.delete();
      for (int i = 0; i < 10 + int'($urandom_range(15)); i++) prog.push_back(rand_bundle());
      run_prog(1'b0, 256, 1'b1, -1);
    end
    rnd_ready = 1'b0;

    // Reset while a write is held by mem_ready=0
    sel = 1'b0; cap = 256; exp_issued = 0; exp_err = 0;
    exp_q.delete(); lat_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stall_cnt = 100;
    send(mk(5'b01100, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3), 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("pre_rst_held_we", 32'(a_we), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_mem_we", 32'(a_we), 32'd0);
    check("midrst_addr", 32'(a_addr), 32'd0);
    check("midrst_wdata", a_wdata, 32'd0);
    check("midrst_count", 32'(a_count), 32'd0);
    check("midrst_in_ready", 32'(a_in_ready), 32'd0);
    check("midrst_err", 32'(a_err), 32'd0);
    stall_cnt = 0;
    exp_q.delete(); lat_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    prog.delete();
    prog.push_back(mk(5'b01100, 3'd0, 1'b1, 5'd5, 5'd6, 5'd7, 32'd0, 32'h407302B3));
    prog.push_back(mk(5'b00101, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'h12345000, 32'h12345117));
    run_prog(1'b0, 256, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
